// File: rtl/blink_pkg.sv
// Shared types and helpers for the speed-selectable LED blinker.
package blink_pkg;

   localparam int                 LEVEL_W   = 3;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 3'd7;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN = 3'd0;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   // LED half-period in ms ticks for a given speed level.
   function automatic int half_ticks(input int base, input logic [LEVEL_W-1:0] level);
      return base >> level;
   endfunction

endpackage

// File: rtl/blink_speed_ctrl_prescaler.sv
// Divides CLK down to a one-cycle TICK every TICK_DIV enabled cycles.
module tick_prescaler #(
   parameter int TICK_DIV = 125000
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic CLR,
   output logic TICK
);

   localparam int               CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             at_last_s;

   // Terminal-count decode; the tick only fires while counting is enabled.
   always_comb begin
      at_last_s = (cnt_r == LAST);
      if (EN) begin
         TICK = at_last_s;
      end else begin
         TICK = 1'b0;
      end
   end

   // Free-running count, cleared by restart, frozen while disabled.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_r <= '0;
      end else if (CLR) begin
         cnt_r <= '0;
      end else if (EN) begin
         if (at_last_s) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/blink_speed_ctrl.sv
// Speed-selectable LED blinker: UP/DN pulses pick a 3-bit level, PAUSE freezes the blink.
module blink_speed_ctrl
   import blink_pkg::*;
#(
   parameter int TICK_DIV     = 125000,
   parameter int BASE_HALF_MS = 512
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               BTN_UP,
   input  logic               BTN_DN,
   input  logic               BTN_PAUSE,
   output logic               LED,
   output logic [LEVEL_W-1:0] LEVEL,
   output logic               PAUSED
);

   localparam int TC_W = $clog2(BASE_HALF_MS);

   state_t             state_r;
   state_t             state_nxt_s;
   logic               paused_r;
   logic               run_s;
   logic [LEVEL_W-1:0] level_r;
   logic [LEVEL_W-1:0] level_nxt_s;
   logic               up_ok_s;
   logic               dn_ok_s;
   logic               restart_s;
   logic               tick_s;
   logic [TC_W-1:0]    tick_cnt_r;
   logic [TC_W-1:0]    half_m1_s;
   logic               led_r;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .CLK  (CLK),
      .RST  (RST),
      .EN   (run_s),
      .CLR  (restart_s),
      .TICK (tick_s)
   );

   // State register; PAUSED is registered from the next state so it tracks state_r.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_RUN;
         paused_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         paused_r <= (state_nxt_s == ST_PAUSE);
      end
   end

   // Next-state logic: every PAUSE pulse flips RUN/PAUSE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (BTN_PAUSE) begin
               state_nxt_s = ST_PAUSE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (BTN_PAUSE) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_PAUSE;
            end
         end
         default: state_nxt_s = ST_RUN;
      endcase
   end

   // FSM output decode: counters advance only in RUN.
   always_comb begin
      run_s = 1'b0;
      case (state_r)
         ST_RUN:   run_s = 1'b1;
         ST_PAUSE: run_s = 1'b0;
         default:  run_s = 1'b0;
      endcase
   end

   // Level step decode: conflicting or saturating presses change nothing and never restart.
   always_comb begin
      up_ok_s     = BTN_UP && !BTN_DN && (level_r != LEVEL_MAX);
      dn_ok_s     = BTN_DN && !BTN_UP && (level_r != LEVEL_MIN);
      restart_s   = up_ok_s || dn_ok_s;
      level_nxt_s = level_r;
      if (up_ok_s) begin
         level_nxt_s = level_r + 3'd1;
      end else if (dn_ok_s) begin
         level_nxt_s = level_r - 3'd1;
      end else begin
         level_nxt_s = level_r;
      end
   end

   // Speed level register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         level_r <= LEVEL_MIN;
      end else begin
         level_r <= level_nxt_s;
      end
   end

   // Terminal count for the current level's half-period.
   always_comb begin
      half_m1_s = TC_W'(half_ticks(BASE_HALF_MS, level_r) - 1);
   end

   // Half-period tick counter and LED toggle; a restart zeroes the count but keeps the LED.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tick_cnt_r <= '0;
         led_r      <= 1'b0;
      end else if (restart_s) begin
         tick_cnt_r <= '0;
         led_r      <= led_r;
      end else if (tick_s) begin
         if (tick_cnt_r == half_m1_s) begin
            tick_cnt_r <= '0;
            led_r      <= ~led_r;
         end else begin
            tick_cnt_r <= tick_cnt_r + TC_W'(1'b1);
            led_r      <= led_r;
         end
      end else begin
         tick_cnt_r <= tick_cnt_r;
         led_r      <= led_r;
      end
   end

   assign LED    = led_r;
   assign LEVEL  = level_r;
   assign PAUSED = paused_r;

endmodule

// File: tb/tb_blink_speed_ctrl.sv
// Directed self-checking bench for blink_speed_ctrl with TICK_DIV=4, BASE_HALF_MS=512.
module tb_blink_speed_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       BTN_UP = 1'b0;
   logic       BTN_DN = 1'b0;
   logic       BTN_PAUSE = 1'b0;
   logic       LED;
   logic [2:0] LEVEL;
   logic       PAUSED;

   int checks = 0;
   int errors = 0;
   int n;
   logic held_led;

   blink_speed_ctrl #(
      .TICK_DIV     (4),
      .BASE_HALF_MS (512)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .BTN_UP    (BTN_UP),
      .BTN_DN    (BTN_DN),
      .BTN_PAUSE (BTN_PAUSE),
      .LED       (LED),
      .LEVEL     (LEVEL),
      .PAUSED    (PAUSED)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(negedge CLK);
   endtask

   // One-cycle pulse; returns at the negedge right after the capturing posedge.
   task automatic pulse(input logic up, input logic dn, input logic pause);
      BTN_UP    = up;
      BTN_DN    = dn;
      BTN_PAUSE = pause;
      @(negedge CLK);
      BTN_UP    = 1'b0;
      BTN_DN    = 1'b0;
      BTN_PAUSE = 1'b0;
   endtask

   // Cycles until LED changes; returns the budget on timeout.
   task automatic wait_toggle(input int budget, output int cycles);
      logic start;
      start  = LED;
      cycles = 0;
      while (cycles < budget) begin
         @(negedge CLK);
         cycles++;
         if (LED !== start) break;
      end
   endtask

   initial begin
      idle(3);
      chk("reset_led", LED, 0);
      chk("reset_level", LEVEL, 0);
      chk("reset_paused", PAUSED, 0);
      RST = 1'b0;

      // Level 0: 512 ticks * 4 clocks per half-period
      wait_toggle(5000, n);
      chk("first_rise_cycles", n, 2048);
      chk("first_rise_led", LED, 1);
      wait_toggle(5000, n);
      chk("second_toggle_cycles", n, 2048);
      chk("idle_level", LEVEL, 0);
      chk("idle_paused", PAUSED, 0);

      // Step up to 7, checking each one-cycle update
      for (int i = 1; i <= 7; i++) begin
         pulse(1'b1, 1'b0, 1'b0);
         chk("level_up", LEVEL, i);
         if (i < 7) idle(99);
      end
      wait_toggle(5000, n);
      chk("level7_half", n, 16);
      idle(5);
      pulse(1'b1, 1'b0, 1'b0);
      chk("up_saturate_level", LEVEL, 7);
      wait_toggle(5000, n);
      chk("up_saturate_no_restart", n, 10);

      // Step down to 0
      for (int i = 6; i >= 0; i--) begin
         pulse(1'b0, 1'b1, 1'b0);
         chk("level_dn", LEVEL, i);
      end
      idle(100);
      pulse(1'b0, 1'b1, 1'b0);
      chk("dn_saturate_level", LEVEL, 0);
      wait_toggle(5000, n);
      chk("dn_saturate_no_restart", n, 1947);

      // Level 3, then simultaneous UP+DN is ignored
      repeat (3) pulse(1'b1, 1'b0, 1'b0);
      chk("level3", LEVEL, 3);
      idle(50);
      pulse(1'b1, 1'b1, 1'b0);
      chk("both_level", LEVEL, 3);
      wait_toggle(5000, n);
      chk("both_no_restart", n, 205);

      // Level 2 pause mid half-period
      pulse(1'b0, 1'b1, 1'b0);
      chk("level2", LEVEL, 2);
      wait_toggle(5000, n);
      chk("level2_half", n, 512);
      idle(299);
      pulse(1'b0, 1'b0, 1'b1);
      chk("pause_flag", PAUSED, 1);
      held_led = LED;
      idle(1000);
      chk("pause_led_frozen", LED, held_led);
      chk("pause_flag_hold", PAUSED, 1);
      pulse(1'b0, 1'b0, 1'b1);
      chk("resume_flag", PAUSED, 0);
      wait_toggle(5000, n);
      chk("resume_remaining", n, 212);

      // Level change while paused zeroes counters, LED held
      pulse(1'b0, 1'b1, 1'b0);
      chk("level1", LEVEL, 1);
      pulse(1'b0, 1'b0, 1'b1);
      chk("pause2_flag", PAUSED, 1);
      idle(37);
      held_led = LED;
      pulse(1'b1, 1'b0, 1'b0);
      chk("paused_up_level", LEVEL, 2);
      idle(200);
      chk("paused_up_led_held", LED, held_led);
      pulse(1'b0, 1'b0, 1'b1);
      chk("resume2_flag", PAUSED, 0);
      wait_toggle(5000, n);
      chk("resume_after_restart", n, 512);

      // PAUSE together with UP: both act in the same edge
      pulse(1'b1, 1'b0, 1'b1);
      chk("pause_up_level", LEVEL, 3);
      chk("pause_up_flag", PAUSED, 1);
      idle(20);
      pulse(1'b0, 1'b0, 1'b1);
      wait_toggle(5000, n);
      chk("pause_up_resume", n, 256);

      // Reset mid-period at level 5 with LED=1
      repeat (2) pulse(1'b1, 1'b0, 1'b0);
      chk("level5", LEVEL, 5);
      if (LED !== 1'b1) wait_toggle(5000, n);
      chk("pre_reset_led", LED, 1);
      idle(10);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("mid_reset_led", LED, 0);
      chk("mid_reset_level", LEVEL, 0);
      chk("mid_reset_paused", PAUSED, 0);
      wait_toggle(5000, n);
      chk("post_reset_toggle", n, 2048);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
